i2c_wb_sequencer: RTL and testbench
===================================

I2C_WB_SEQUENCER -- requirements
Module: i2c_wb_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd50000, maximum cycles spent waiting for byte completion.
REQ-002 SHALL have ports, in this order:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- prescale  in  16  SCL prescale value written to the core during init.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_rw  in  1  transfer direction: 1=read, 0=write.
- cmd_addr  in  7  I2C slave address.
- cmd_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte.
- rsp_nack  out  1  slave NACKed the address or data.
- rsp_timeout  out  1  byte-completion timeout.
- addr_in  out  8  WB address to the core.
- data_in  out  8  WB write data.
- data_out  in  8  WB read data.
- wb_stb_i  out  1  WB strobe.
- wb_cyc_i  out  1  WB cycle.
- we  out  1  WB write enable.
- ack_o  in  1  WB acknowledge.
- trans_comp  in  1  byte transfer complete.
- irq  in  1  core interrupt.

Function
REQ-003 SHALL accept a command on the clk edge where cmd_valid && cmd_ready; cmd_ready=1 only in IDLE.
REQ-004 SHALL register cmd_rw, cmd_addr and cmd_wdata at acceptance; input changes afterwards are ignored.
REQ-005 SHALL run each WB access as a single classic cycle:
- Drive cyc, stb, we, addr and data together and hold them stable until ack_o=1 is sampled.
- Deassert cyc and stb on the following edge.
- Capture data_out on the ack edge.
- Keep at least one idle cycle between accesses.
REQ-006 SHALL use FSM states IDLE, INIT, ADDR, WAIT_A, STAT_A, DATA, WAIT_D, STAT_D, RXRD, STOP, RESP.
REQ-007 SHALL enter INIT on the first command after reset, then IDLE→ADDR for every later command. INIT writes PRER_LO=prescale[7:0], then PRER_HI=prescale[15:8], then CTRL=CTRL_EN, and sets init_done.
REQ-008 ADDR SHALL write TXRX={addr,rw}, then CMD=CMD_STA|CMD_WR, then go to WAIT_A.
REQ-009 WAIT_A and WAIT_D SHALL exit when trans_comp||irq is sampled high; the timeout counter clears on entry.
REQ-010 SHALL take the STOP path with rsp_timeout=1 when the counter reaches TIMEOUT_CYC before completion; if completion and terminal count coincide, completion wins.
REQ-011 STAT_A SHALL read STAT: if STAT_RXACK=1, set nack and go to STOP; otherwise go to DATA.
REQ-012 DATA SHALL behave by direction:
- Write: write TXRX=wdata, then CMD=CMD_WR|CMD_STO.
- Read: write CMD=CMD_RD|CMD_ACK|CMD_STO (master NACKs the last byte).
- Both then go to WAIT_D.
REQ-013 After WAIT_D, SHALL go to STAT_D on a write (STAT read; RXACK=1 sets nack) and to RXRD on a read (TXRX read into rsp_rdata); both then go to RESP.
REQ-014 STOP SHALL write CMD=CMD_STO, then go to RESP.
REQ-015 RESP SHALL pulse rsp_valid for exactly one cycle with rsp_rdata, rsp_nack and rsp_timeout valid in that cycle, then return to IDLE. Flags hold until the next acceptance; rsp_rdata=0 on a write or on an error.
REQ-016 Latency is not fixed: it is bounded by WB ack delays plus 2×TIMEOUT_CYC.

Reset
REQ-017 On rst=1, SHALL immediately enter IDLE, clear init_done and the timeout counter, and drive all outputs 0 except cmd_ready=1. This applies mid-WB-cycle: cyc and stb drop asynchronously.
REQ-018 After reset release, SHALL repeat INIT before the next transfer.

Structure
REQ-019 Package i2c_seq_pkg SHALL hold:
- Register addresses: PRER_LO=8'h00, PRER_HI=8'h01, CTRL=8'h02, TXRX=8'h03, CMD/STAT=8'h04.
- CTRL bit: CTRL_EN=bit7.
- CMD bits: CMD_STA=bit7, CMD_STO=bit6, CMD_RD=bit5, CMD_WR=bit4, CMD_ACK=bit3.
- STAT bit: STAT_RXACK=bit7.
- The FSM state enum.
REQ-020 The single-access WB handshake SHALL be the sub-module i2c_wb_access (req/wr/addr/wdata in; done/rdata out).

Verification
REQ-021 Write, no faults: prescale=16'h0063, write 0x5A to addr 0x50, ack_o after 1 cycle → WB writes 00←63, 01←00, 02←80, 03←A0, 04←90, 03←5A, 04←50; one rsp_valid with nack=0 and timeout=0.
REQ-022 Read: addr 0x50 rw=1, second command, TXRX read returns 0xC3 → no INIT writes; 03←A1, 04←90, 04←68; rsp_rdata=0xC3.
REQ-023 Address NACK: STAT read returns 0x80 → 04←40 written; rsp_nack=1; no TXRX data write.
REQ-024 Timeout: TIMEOUT_CYC=20, trans_comp never asserted → rsp_timeout=1 after 20 wait cycles, STOP write issued; completion on cycle 20 → no timeout.
REQ-025 Reset mid-access: rst asserted while stb=1 and ack_o withheld → cyc/stb=0 without a clock edge; next command re-runs INIT.
REQ-026 Slow slave: ack_o delayed 5 cycles on every access → addr/data/we stable throughout; the result is identical to REQ-021.

Source files
------------

// File: rtl/i2c_wb_sequencer_pkg.sv
// Shared constants and state encoding for the I2C Wishbone sequencer.
// Register map and bit masks follow the OpenCores I2C master core.
package i2c_seq_pkg;

    // Core register addresses (CMD and STAT share one address: write vs read)
    localparam logic [7:0] PRER_LO = 8'h00;
    localparam logic [7:0] PRER_HI = 8'h01;
    localparam logic [7:0] CTRL    = 8'h02;
    localparam logic [7:0] TXRX    = 8'h03;
    localparam logic [7:0] CMD     = 8'h04;
    localparam logic [7:0] STAT    = 8'h04;

    // CTRL register: core enable
    localparam logic [7:0] CTRL_EN = 8'h80;

    // CMD register bits
    localparam logic [7:0] CMD_STA = 8'h80;
    localparam logic [7:0] CMD_STO = 8'h40;
    localparam logic [7:0] CMD_RD  = 8'h20;
    localparam logic [7:0] CMD_WR  = 8'h10;
    localparam logic [7:0] CMD_ACK = 8'h08;

    // STAT register: bit index of the received-ACK flag (1 = slave NACKed)
    localparam int STAT_RXACK = 7;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ADDR,
        WAIT_A,
        STAT_A,
        DATA,
        WAIT_D,
        STAT_D,
        RXRD,
        STOP,
        RESP
    } seq_state_t;

endpackage

// File: rtl/i2c_wb_sequencer_if.sv
// Wishbone bus between the sequencer (master) and the I2C core (slave).
// Handshake: a classic cycle; the master raises cyc and stb together with
// we/addr_in/data_in and keeps all of them stable until it samples ack_o=1,
// then drops cyc/stb on that same edge. data_out is valid while ack_o=1.
interface i2c_wb_sequencer_if;
    logic [7:0] addr_in;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wb_stb_i;
    logic       wb_cyc_i;
    logic       we;
    logic       ack_o;

    modport master (
        output addr_in, data_in, wb_stb_i, wb_cyc_i, we,
        input  data_out, ack_o
    );

    modport slave (
        input  addr_in, data_in, wb_stb_i, wb_cyc_i, we,
        output data_out, ack_o
    );
endinterface

// File: rtl/i2c_wb_sequencer_access.sv
// Single Wishbone classic-cycle engine. A req pulse launches one access;
// done pulses one cycle after the ack edge, with rdata captured on that edge.
module i2c_wb_access (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    i2c_wb_sequencer_if.master wb
);

    logic       active;
    logic       we_q;
    logic       done_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;

    // Launch on req, hold the bus stable until ack, then release and report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (active) begin
                if (wb.ack_o) begin
                    active  <= 1'b0;
                    done_q  <= 1'b1;
                    rdata_q <= wb.data_out;
                end
            end else if (req) begin
                active  <= 1'b1;
                we_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    assign wb.wb_cyc_i = active;
    assign wb.wb_stb_i = active;
    assign wb.we       = we_q;
    assign wb.addr_in  = addr_q;
    assign wb.data_in  = wdata_q;
    assign done        = done_q;
    assign rdata       = rdata_q;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Command-level I2C sequencer: turns one read/write byte command into the
// Wishbone register accesses an OpenCores-style I2C master core expects.
// Command handshake: accepted on the edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE. rsp_valid pulses once per command.
module i2c_wb_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] prescale,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_nack,
    output logic        rsp_timeout,
    output logic [7:0]  addr_in,
    output logic [7:0]  data_in,
    input  logic [7:0]  data_out,
    output logic        wb_stb_i,
    output logic        wb_cyc_i,
    output logic        we,
    input  logic        ack_o,
    input  logic        trans_comp,
    input  logic        irq
);

    seq_state_t  state, state_n;
    logic [1:0]  step, step_n;     // access index within a multi-access state
    logic        pend, pend_n;     // an access of this step is in flight
    logic        init_done;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        nack_q;
    logic        timeout_q;
    logic [7:0]  rdata_q;
    logic [15:0] cnt;

    logic        accept;
    logic        in_wait;
    logic        xfer_comp;
    logic        term;
    logic        expired;
    logic        op_valid;
    logic        op_wr;
    logic [7:0]  op_addr;
    logic [7:0]  op_wdata;
    logic        acc_req;
    logic        acc_done;
    logic [7:0]  acc_rdata;

    i2c_wb_sequencer_if wb_bus ();

    assign addr_in         = wb_bus.addr_in;
    assign data_in         = wb_bus.data_in;
    assign wb_stb_i        = wb_bus.wb_stb_i;
    assign wb_cyc_i        = wb_bus.wb_cyc_i;
    assign we              = wb_bus.we;
    assign wb_bus.data_out = data_out;
    assign wb_bus.ack_o    = ack_o;

    i2c_wb_access u_access (
        .clk   (clk),
        .rst   (rst),
        .req   (acc_req),
        .wr    (op_wr),
        .addr  (op_addr),
        .wdata (op_wdata),
        .done  (acc_done),
        .rdata (acc_rdata),
        .wb    (wb_bus)
    );

    assign accept    = cmd_valid && cmd_ready;
    assign in_wait   = (state == WAIT_A) || (state == WAIT_D);
    assign xfer_comp = trans_comp || irq;
    // Terminal count is the last wait cycle; completion seen in it still wins
    assign term      = (cnt == TIMEOUT_CYC - 16'd1);
    assign expired   = in_wait && !xfer_comp && term;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= 2'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            step  <= step_n;
            pend  <= pend_n;
        end
    end

    // Next-state: advance a step on every finished access, leave when done
    always_comb begin
        state_n = state;
        step_n  = step;
        pend_n  = pend;
        if (acc_req)  pend_n = 1'b1;
        if (acc_done) pend_n = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n = init_done ? ADDR : INIT;
                step_n  = 2'd0;
            end
            INIT: if (acc_done) begin
                if (step == 2'd2) begin
                    state_n = ADDR;
                    step_n  = 2'd0;
                end else begin
                    step_n = step + 2'd1;
                end
            end
            ADDR: if (acc_done) begin
                if (step == 2'd1) begin
                    state_n = WAIT_A;
                    step_n  = 2'd0;
                end else begin
                    step_n = step + 2'd1;
                end
            end
            WAIT_A: begin
                if (xfer_comp) state_n = STAT_A;
                else if (term) state_n = STOP;
            end
            STAT_A: if (acc_done) state_n = acc_rdata[STAT_RXACK] ? STOP : DATA;
            DATA: if (acc_done) begin
                // A read needs only the command write; a write loads TXRX first
                if (rw_q || step == 2'd1) begin
                    state_n = WAIT_D;
                    step_n  = 2'd0;
                end else begin
                    step_n = step + 2'd1;
                end
            end
            WAIT_D: begin
                if (xfer_comp) state_n = rw_q ? RXRD : STAT_D;
                else if (term) state_n = STOP;
            end
            STAT_D, RXRD, STOP: if (acc_done) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs: which register access the current state/step performs
    always_comb begin
        op_valid = 1'b0;
        op_wr    = 1'b1;
        op_addr  = 8'h00;
        op_wdata = 8'h00;
        case (state)
            INIT: begin
                op_valid = 1'b1;
                case (step)
                    2'd0:    begin op_addr = PRER_LO; op_wdata = prescale[7:0];  end
                    2'd1:    begin op_addr = PRER_HI; op_wdata = prescale[15:8]; end
                    default: begin op_addr = CTRL;    op_wdata = CTRL_EN;        end
                endcase
            end
            ADDR: begin
                op_valid = 1'b1;
                if (step == 2'd0) begin
                    op_addr  = TXRX;
                    op_wdata = {addr_q, rw_q};
                end else begin
                    op_addr  = CMD;
                    op_wdata = CMD_STA | CMD_WR;
                end
            end
            STAT_A, STAT_D: begin
                op_valid = 1'b1;
                op_wr    = 1'b0;
                op_addr  = STAT;
            end
            DATA: begin
                op_valid = 1'b1;
                if (rw_q) begin
                    // ACK bit set: master NACKs the single byte it reads
                    op_addr  = CMD;
                    op_wdata = CMD_RD | CMD_ACK | CMD_STO;
                end else if (step == 2'd0) begin
                    op_addr  = TXRX;
                    op_wdata = wdata_q;
                end else begin
                    op_addr  = CMD;
                    op_wdata = CMD_WR | CMD_STO;
                end
            end
            RXRD: begin
                op_valid = 1'b1;
                op_wr    = 1'b0;
                op_addr  = TXRX;
            end
            STOP: begin
                op_valid = 1'b1;
                op_addr  = CMD;
                op_wdata = CMD_STO;
            end
            default: op_valid = 1'b0;
        endcase
        acc_req = op_valid && !pend;
    end

    // Command capture, result flags and the completion-wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= 7'h00;
            wdata_q   <= 8'h00;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= 8'h00;
            cnt       <= 16'd0;
        end else begin
            if (accept) begin
                rw_q      <= cmd_rw;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                nack_q    <= 1'b0;
                timeout_q <= 1'b0;
                rdata_q   <= 8'h00;
            end
            if (state == INIT && acc_done && step == 2'd2) init_done <= 1'b1;
            if ((state == STAT_A || state == STAT_D) && acc_done && acc_rdata[STAT_RXACK])
                nack_q <= 1'b1;
            if (state == RXRD && acc_done) rdata_q <= acc_rdata;
            if (expired) timeout_q <= 1'b1;
            cnt <= in_wait ? cnt + 16'd1 : 16'd0;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Bench for i2c_wb_sequencer: a reactive I2C-core model on the Wishbone side,
// a transaction-level scoreboard of expected register accesses and responses.
module tb_i2c_wb_sequencer;

    localparam int TMO = 20;

    logic        clk;
    logic        rst;
    logic [15:0] prescale;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic        rsp_timeout;
    logic        trans_comp;
    logic        irq;

    i2c_wb_sequencer_if bus ();

    i2c_wb_sequencer #(.TIMEOUT_CYC(16'd20)) dut (
        .clk         (clk),
        .rst         (rst),
        .prescale    (prescale),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_nack    (rsp_nack),
        .rsp_timeout (rsp_timeout),
        .addr_in     (bus.addr_in),
        .data_in     (bus.data_in),
        .data_out    (bus.data_out),
        .wb_stb_i    (bus.wb_stb_i),
        .wb_cyc_i    (bus.wb_cyc_i),
        .we          (bus.we),
        .ack_o       (bus.ack_o),
        .trans_comp  (trans_comp),
        .irq         (irq)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    logic [16:0] exp_q[$];   // {we, addr, data}; reads carry data 0
    logic [15:0] log_q[$];   // observed writes {addr, data}
    logic [15:0] lit_q[$];   // hand-written literal write list
    logic [7:0]  stat_q[$];  // values the core model returns on STAT reads

    logic        exp_nack, exp_to;
    logic [7:0]  exp_rdata;
    logic        need_init;
    int          ack_dly;
    int          comp_a_at, comp_d_at;
    logic        use_irq;
    logic [7:0]  rx_val;
    int          rsp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [16:0] wr_ent(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] rd_ent(input logic [7:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    function automatic logic comp_ok(input int at);
        return (at >= 1) && (at <= TMO);
    endfunction

    // Expected register traffic and response for one command, from the
    // documented transfer recipe of the core.
    task automatic build_model(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                               input int ca, input int cd,
                               input logic [7:0] sa, input logic [7:0] sd, input logic [7:0] rx);
        exp_nack  = 1'b0;
        exp_to    = 1'b0;
        exp_rdata = 8'h00;
        if (need_init) begin
            exp_q.push_back(wr_ent(8'h00, prescale[7:0]));
            exp_q.push_back(wr_ent(8'h01, prescale[15:8]));
            exp_q.push_back(wr_ent(8'h02, 8'h80));
        end
        exp_q.push_back(wr_ent(8'h03, {a, rw}));
        exp_q.push_back(wr_ent(8'h04, 8'h90));
        if (!comp_ok(ca)) begin
            exp_q.push_back(wr_ent(8'h04, 8'h40));
            exp_to = 1'b1;
        end else begin
            exp_q.push_back(rd_ent(8'h04));
            if (sa[7]) begin
                exp_q.push_back(wr_ent(8'h04, 8'h40));
                exp_nack = 1'b1;
            end else begin
                if (!rw) begin
                    exp_q.push_back(wr_ent(8'h03, wd));
                    exp_q.push_back(wr_ent(8'h04, 8'h50));
                end else begin
                    exp_q.push_back(wr_ent(8'h04, 8'h68));
                end
                if (!comp_ok(cd)) begin
                    exp_q.push_back(wr_ent(8'h04, 8'h40));
                    exp_to = 1'b1;
                end else if (!rw) begin
                    exp_q.push_back(rd_ent(8'h04));
                    exp_nack = sd[7];
                end else begin
                    exp_q.push_back(rd_ent(8'h03));
                    exp_rdata = rx;
                end
            end
        end
    endtask

    // ---------------- core model + compare process ----------------
    initial begin : core_model
        int          n_acc;
        int          tc_timer;
        logic        prev_rsp;
        logic [16:0] rec;
        logic [16:0] act;
        logic [7:0]  rv;
        int          at;
        n_acc        = 0;
        tc_timer     = 0;
        prev_rsp     = 1'b0;
        rec          = '0;
        bus.ack_o    = 1'b0;
        bus.data_out = 8'h00;
        trans_comp   = 1'b0;
        irq          = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.ack_o  = 1'b0;
                n_acc      = 0;
                tc_timer   = 0;
                trans_comp = 1'b0;
                irq        = 1'b0;
                prev_rsp   = 1'b0;
            end else begin
                trans_comp = 1'b0;
                irq        = 1'b0;
                if (tc_timer > 0) begin
                    tc_timer--;
                    if (tc_timer == 0) begin
                        if (use_irq) irq = 1'b1;
                        else         trans_comp = 1'b1;
                    end
                end
                if (bus.wb_cyc_i !== bus.wb_stb_i)
                    chk("cyc_eq_stb", {31'd0, bus.wb_stb_i}, {31'd0, bus.wb_cyc_i});
                if (bus.ack_o) begin
                    chk("cyc_drop_after_ack", {30'd0, bus.wb_cyc_i, bus.wb_stb_i}, 32'd0);
                    bus.ack_o = 1'b0;
                    n_acc     = 0;
                end else if (bus.wb_cyc_i) begin
                    act = bus.we ? {1'b1, bus.addr_in, bus.data_in} : {1'b0, bus.addr_in, 8'h00};
                    if (n_acc == 0) rec = act;
                    else chk("bus_stable", {15'd0, act}, {15'd0, rec});
                    n_acc++;
                    if (n_acc > ack_dly) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL unexpected_access: got %0h expected none", act);
                        end else begin
                            chk("wb_access", {15'd0, act}, {15'd0, exp_q.pop_front()});
                        end
                        if (bus.we) log_q.push_back({bus.addr_in, bus.data_in});
                        rv = 8'hEE;
                        if (!bus.we && bus.addr_in == 8'h04)
                            rv = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
                        else if (!bus.we && bus.addr_in == 8'h03)
                            rv = rx_val;
                        bus.data_out = rv;
                        bus.ack_o    = 1'b1;
                        if (bus.we && bus.addr_in == 8'h04 && (bus.data_in & 8'hB0) != 8'h00) begin
                            at = bus.data_in[7] ? comp_a_at : comp_d_at;
                            tc_timer = (at > 0) ? at + 1 : 0;
                        end
                    end
                end
                if (bus.wb_cyc_i) chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
                if (rsp_valid) begin
                    chk("rsp_one_cycle", {31'd0, prev_rsp}, 32'd0);
                    chk("rsp_rdata",   {24'd0, rsp_rdata},   {24'd0, exp_rdata});
                    chk("rsp_nack",    {31'd0, rsp_nack},    {31'd0, exp_nack});
                    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
                    rsp_cnt++;
                end else if (prev_rsp) begin
                    chk("hold_rdata",   {24'd0, rsp_rdata},   {24'd0, exp_rdata});
                    chk("hold_nack",    {31'd0, rsp_nack},    {31'd0, exp_nack});
                    chk("hold_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] wd);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs: the command must already be captured
        cmd_valid = 1'b0;
        cmd_rw    = ~rw;
        cmd_addr  = ~a;
        cmd_wdata = ~wd;
    endtask

    task automatic run_cmd(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                           input int ca, input int cd,
                           input logic [7:0] sa, input logic [7:0] sd, input logic [7:0] rx);
        int start;
        @(negedge clk);
        log_q.delete();
        stat_q.delete();
        stat_q.push_back(sa);
        stat_q.push_back(sd);
        rx_val    = rx;
        comp_a_at = ca;
        comp_d_at = cd;
        build_model(rw, a, wd, ca, cd, sa, sd, rx);
        start = rsp_cnt;
        issue(rw, a, wd);
        for (int i = 0; i < 3000 && rsp_cnt == start; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rsp_count", 32'(rsp_cnt - start), 32'd1);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        need_init = 1'b0;
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(log_q.size()), 32'(lit_q.size()));
        for (int i = 0; i < lit_q.size() && i < log_q.size(); i++)
            chk(name, {16'd0, log_q[i]}, {16'd0, lit_q[i]});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        prescale  = 16'h0063;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = 7'h00;
        cmd_wdata = 8'h00;
        need_init = 1'b1;
        ack_dly   = 1;
        comp_a_at = 0;
        comp_d_at = 0;
        use_irq   = 1'b0;
        rx_val    = 8'h00;
        #2;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_rsp", {28'd0, rsp_valid, rsp_nack, rsp_timeout, 1'b0}, 32'd0);
        chk("reset_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("reset_bus", {13'd0, bus.wb_cyc_i, bus.wb_stb_i, bus.we, bus.addr_in, bus.data_in}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Write 0x5A to 0x50, first command: full init sequence
        run_cmd(1'b0, 7'h50, 8'h5A, 3, 3, 8'h00, 8'h00, 8'h00);
        lit_q = {16'h0063, 16'h0100, 16'h0280, 16'h03A0, 16'h0490, 16'h035A, 16'h0450};
        check_log("log_write");

        // Read from 0x50, zero-wait acks and earliest completion
        ack_dly = 0;
        run_cmd(1'b1, 7'h50, 8'h00, 1, 1, 8'h00, 8'h00, 8'hC3);
        lit_q = {16'h03A1, 16'h0490, 16'h0468};
        check_log("log_read");
        chk("lit_read_rdata", {24'd0, rsp_rdata}, 32'h0000_00C3);

        // Address NACK: STOP issued, no data write
        ack_dly = 1;
        run_cmd(1'b0, 7'h22, 8'h11, 2, 2, 8'h80, 8'h00, 8'h00);
        lit_q = {16'h0344, 16'h0490, 16'h0440};
        check_log("log_addr_nack");
        chk("lit_nack", {31'd0, rsp_nack}, 32'd1);

        // No completion in address phase: timeout path
        run_cmd(1'b0, 7'h0A, 8'h77, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("lit_timeout", {31'd0, rsp_timeout}, 32'd1);

        // Completion on the last allowed wait cycle, then one cycle late
        run_cmd(1'b1, 7'h31, 8'h00, TMO, TMO + 1, 8'h00, 8'h00, 8'h99);
        chk("lit_late_rdata", {24'd0, rsp_rdata}, 32'd0);

        // Completion via irq, data-phase NACK
        use_irq = 1'b1;
        run_cmd(1'b0, 7'h3C, 8'hFF, 2, 4, 8'h00, 8'h80, 8'h00);
        use_irq = 1'b0;

        // Reset while a strobe is outstanding and ack is withheld
        @(negedge clk);
        exp_q.delete();
        stat_q.delete();
        ack_dly = 1000;
        issue(1'b0, 7'h50, 8'h5A);
        for (int i = 0; i < 100 && !bus.wb_stb_i; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("stb_before_reset", {31'd0, bus.wb_stb_i}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_drop_bus", {30'd0, bus.wb_cyc_i, bus.wb_stb_i}, 32'd0);
        chk("async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        need_init = 1'b1;

        // Slow slave after reset: init repeats, same traffic as the first write
        ack_dly = 5;
        run_cmd(1'b0, 7'h50, 8'h5A, 3, 3, 8'h00, 8'h00, 8'h00);
        lit_q = {16'h0063, 16'h0100, 16'h0280, 16'h03A0, 16'h0490, 16'h035A, 16'h0450};
        check_log("log_slow");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
